// File: rtl/mux_addr_ctrl.sv
// mux_addr_ctrl: selects one project on a shared mux. Asynchronous control
// pins are synchronized, a shadow counter is stepped to the wanted slot, and
// an enable request commits it through a reset pulse before enabling.

// Single-bit multi-flop synchronizer with synchronous reset.
module mux_addr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  // Shift the raw input through STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

module mux_addr_ctrl #(
  parameter int NUM_PROJECTS = 23,
  parameter int RST_CYCLES   = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_sel_rst,
  input  logic       ctrl_sel_inc,
  input  logic       ctrl_ena,
  output logic [4:0] addr,
  output logic       addr_valid,
  output logic       proj_rst,
  output logic       ena,
  output logic       addr_err
);
  localparam int         NCTRL     = 3;
  localparam logic [4:0] ADDR_NONE = 5'd31;
  localparam logic [7:0] RST_LD    = 8'(RST_CYCLES);
  localparam logic [31:0] NPROJ    = 32'(NUM_PROJECTS);

  typedef enum logic [1:0] {S_IDLE, S_PRST, S_ACTIVE} state_t;

  // Bit order: 0 = sel_rst, 1 = sel_inc, 2 = ena.
  logic [NCTRL-1:0] ctrl_raw, ctrl_s, ctrl_d;
  assign ctrl_raw = {ctrl_ena, ctrl_sel_inc, ctrl_sel_rst};

  for (genvar i = 0; i < NCTRL; i++) begin : g_sync
    mux_addr_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (ctrl_raw[i]),
      .q   (ctrl_s[i])
    );
  end

  // One-cycle delayed copies for edge detection; zero after reset so a level
  // held through reset release is seen as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) ctrl_d <= '0;
    else     ctrl_d <= ctrl_s;
  end

  logic sel_rst_s, inc_rise, ena_s, ena_rise;
  assign sel_rst_s = ctrl_s[0];
  assign inc_rise  = ctrl_s[1] & ~ctrl_d[1];
  assign ena_s     = ctrl_s[2];
  assign ena_rise  = ctrl_s[2] & ~ctrl_d[2];

  logic [4:0] shadow;
  logic       in_range;
  assign in_range = {27'd0, shadow} < NPROJ;

  // Shadow counter: clear dominates, increments saturate at 31.
  always_ff @(posedge clk) begin
    if (rst)                              shadow <= '0;
    else if (sel_rst_s)                   shadow <= '0;
    else if (inc_rise && shadow != 5'd31) shadow <= shadow + 5'd1;
  end

  state_t     state, state_d;
  logic [7:0] rcnt, rcnt_d;
  logic [4:0] addr_d;
  logic       valid_d, prst_d, ena_d, err_d;

  // State, reset-cycle counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rcnt       <= '0;
      addr       <= ADDR_NONE;
      addr_valid <= 1'b0;
      proj_rst   <= 1'b0;
      ena        <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_d;
      rcnt       <= rcnt_d;
      addr       <= addr_d;
      addr_valid <= valid_d;
      proj_rst   <= prst_d;
      ena        <= ena_d;
      addr_err   <= err_d;
    end
  end

  // Next state: a dropped enable wins over the reset countdown.
  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    case (state)
      S_IDLE: begin
        if (ena_rise && in_range) begin
          state_d = S_PRST;
          rcnt_d  = RST_LD;
        end
      end
      S_PRST: begin
        if (!ena_s) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (rcnt == 8'd1) begin
          state_d = S_ACTIVE;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt - 8'd1;
        end
      end
      S_ACTIVE: begin
        if (!ena_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // Next output values from the next state, so outputs come straight off flops.
  always_comb begin
    addr_d  = addr;
    err_d   = addr_err;
    valid_d = (state_d != S_IDLE);
    prst_d  = (state_d == S_PRST);
    ena_d   = (state_d == S_ACTIVE);
    if (state_d == S_IDLE)    addr_d = ADDR_NONE;
    else if (state == S_IDLE) addr_d = shadow;
    if (sel_rst_s)
      err_d = 1'b0;
    else if (state == S_IDLE && ena_rise && !in_range)
      err_d = 1'b1;
  end
endmodule

// File: tb/tb_mux_addr_ctrl.sv
// Directed bench for mux_addr_ctrl with default parameters (23 slots,
// 8-cycle project reset, 2-stage synchronizers).
module tb_mux_addr_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ctrl_sel_rst = 1'b0;
  logic       ctrl_sel_inc = 1'b0;
  logic       ctrl_ena = 1'b0;
  logic [4:0] addr;
  logic       addr_valid, proj_rst, ena, addr_err;

  int n_run = 0;
  int n_fail = 0;

  // Hold monitor: counts cycles where addr/ena deviate from expectation.
  bit         mon_on = 1'b0;
  logic [4:0] mon_addr = '0;
  logic       mon_ena = 1'b0;
  int         mon_bad = 0;

  mux_addr_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_sel_rst (ctrl_sel_rst),
    .ctrl_sel_inc (ctrl_sel_inc),
    .ctrl_ena     (ctrl_ena),
    .addr         (addr),
    .addr_valid   (addr_valid),
    .proj_rst     (proj_rst),
    .ena          (ena),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mon_on && (addr !== mon_addr || ena !== mon_ena)) mon_bad++;
    end
  endtask

  task automatic inc_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_sel_inc = 1'b1; cyc(3);
      ctrl_sel_inc = 1'b0; cyc(3);
    end
  endtask

  task automatic srst_pulse();
    ctrl_sel_rst = 1'b1; cyc(3);
    ctrl_sel_rst = 1'b0; cyc(3);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"},  addr, 31);
    chk({tag, "_valid"}, addr_valid, 0);
    chk({tag, "_prst"},  proj_rst, 0);
    chk({tag, "_ena"},   ena, 0);
  endtask

  initial begin
    int n;
    cyc(2);
    chk_idle("rst");
    chk("rst_err", addr_err, 0);
    rst = 1'b0;
    cyc(2);

    // Select slot 5 and enable: 2 sync cycles, 8 reset cycles, then active.
    inc_pulse(5);
    ctrl_ena = 1'b1;
    cyc(2);
    chk("s1_pre_prst", proj_rst, 0);
    cyc(1);
    chk("s1_addr", addr, 5);
    chk("s1_valid", addr_valid, 1);
    chk("s1_ena_in_prst", ena, 0);
    n = 0;
    while (proj_rst === 1'b1 && n < 20) begin
      n++;
      cyc(1);
    end
    chk("s1_prst_len", n, 8);
    chk("s1_ena", ena, 1);
    chk("s1_act_valid", addr_valid, 1);
    chk("s1_act_addr", addr, 5);
    ctrl_ena = 1'b0;
    cyc(2);
    chk("s1_drop_late", ena, 1);
    cyc(1);
    chk_idle("s1_drop");

    // Active at slot 7; shadow activity must not disturb addr or ena.
    srst_pulse();
    inc_pulse(7);
    ctrl_ena = 1'b1;
    cyc(11);
    chk("s2_ena", ena, 1);
    chk("s2_addr", addr, 7);
    mon_addr = 5'd7; mon_ena = 1'b1; mon_bad = 0; mon_on = 1'b1;
    inc_pulse(4);
    srst_pulse();
    mon_on = 1'b0;
    chk("s2_hold", mon_bad, 0);
    ctrl_ena = 1'b0;
    cyc(3);
    chk_idle("s2_drop");

    // Coincident inc and sel_rst: clear wins, shadow reads back as 0.
    inc_pulse(3);
    ctrl_sel_inc = 1'b1; ctrl_sel_rst = 1'b1; cyc(3);
    ctrl_sel_inc = 1'b0; ctrl_sel_rst = 1'b0; cyc(3);
    ctrl_ena = 1'b1;
    cyc(3);
    chk("s3_addr", addr, 0);
    chk("s3_prst", proj_rst, 1);
    ctrl_ena = 1'b0;
    cyc(3);

    // Enable dropped 3 cycles into PRST: back to idle, never active.
    inc_pulse(2);
    ctrl_ena = 1'b1;
    cyc(3);
    chk("s4_addr", addr, 2);
    cyc(3);
    ctrl_ena = 1'b0;
    mon_addr = 5'd2; mon_ena = 1'b0; mon_bad = 0; mon_on = 1'b1;
    cyc(2);
    mon_on = 1'b0;
    chk("s4_no_active", mon_bad, 0);
    cyc(1);
    chk_idle("s4_drop");
    mon_addr = 5'd31; mon_bad = 0; mon_on = 1'b1;
    cyc(10);
    mon_on = 1'b0;
    chk("s4_stay_idle", mon_bad, 0);

    // 40 increments saturate at 31: request rejected, sticky error.
    inc_pulse(40);
    ctrl_ena = 1'b1;
    cyc(3);
    chk("s5_err", addr_err, 1);
    chk_idle("s5");
    cyc(10);
    chk("s5_still_idle", addr_valid, 0);
    ctrl_ena = 1'b0;
    cyc(3);
    chk("s5_sticky", addr_err, 1);
    srst_pulse();
    chk("s5_clear", addr_err, 0);

    // Boundary: slot 22 accepted, slot 23 rejected.
    inc_pulse(22);
    ctrl_ena = 1'b1;
    cyc(3);
    chk("b22_addr", addr, 22);
    chk("b22_err", addr_err, 0);
    ctrl_ena = 1'b0;
    cyc(3);
    inc_pulse(1);
    ctrl_ena = 1'b1;
    cyc(3);
    chk("b23_err", addr_err, 1);
    chk("b23_addr", addr, 31);
    ctrl_ena = 1'b0;
    cyc(3);
    srst_pulse();

    // Reset in ACTIVE with enable still high: immediate idle, then slot 0.
    inc_pulse(3);
    ctrl_ena = 1'b1;
    cyc(11);
    chk("s6_ena", ena, 1);
    chk("s6_addr", addr, 3);
    rst = 1'b1;
    cyc(1);
    chk_idle("s6_rst");
    rst = 1'b0;
    cyc(2);
    chk("s6_pre_prst", proj_rst, 0);
    cyc(1);
    chk("s6_reentry_prst", proj_rst, 1);
    chk("s6_reentry_addr", addr, 0);
    ctrl_ena = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_addr_ctrl.md
MUX_ADDR_CTRL -- requirements
Module: mux_addr_ctrl

Interface
REQ-001: Clocking SHALL be one clock with a synchronous, active-high reset: ports clk and rst.
REQ-002: Parameter NUM_PROJECTS, default 23, SHALL be the number of valid project slots (addresses 0..NUM_PROJECTS-1).
REQ-003: Parameter RST_CYCLES, default 8, SHALL be the project-reset pulse length in clk cycles (range 1..255).
REQ-004: Parameter SYNC_STAGES, default 2, SHALL be the synchronizer depth on every ctrl_* input (range 2..4).
REQ-005: Port clk, input, 1, SHALL be the rising-edge system clock.
REQ-006: Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-007: Port ctrl_sel_rst, input, 1, asynchronous, SHALL clear the shadow counter while high.
REQ-008: Port ctrl_sel_inc, input, 1, asynchronous, SHALL increment the shadow counter on each rising edge.
REQ-009: Port ctrl_ena, input, 1, asynchronous level, SHALL request enabling the project at the shadow counter value.
REQ-010: Port addr, output, 5, SHALL be the committed project address driven to the mux; 5'd31 means none selected.
REQ-011: Port addr_valid, output, 1, SHALL be high only in state ACTIVE or PRST.
REQ-012: Port proj_rst, output, 1, SHALL be the active-high reset to the selected project.
REQ-013: Port ena, output, 1, SHALL be the project enable, high only in state ACTIVE.
REQ-014: Port addr_err, output, 1, SHALL be a sticky flag for an enable request with an out-of-range shadow value.

Function
REQ-015: Synchronization SHALL pass every ctrl_* input through SYNC_STAGES flops; all logic SHALL use only the synchronized copies.
REQ-016: Timing SHALL be as follows: an input first sampled high at clk edge N affects registered state at edge N+SYNC_STAGES.
REQ-017: Edge detection SHALL compare the synchronized signal with its one-cycle-delayed copy; the delayed copy is 0 after reset.
REQ-018: Shadow counter SHALL be 5 bits, incrementing by 1 per synchronized ctrl_sel_inc rising edge, saturating at 31 (no wrap).
REQ-019: Counter priority SHALL be that synchronized ctrl_sel_rst high holds the shadow counter at 0 and drops any coincident increment.
REQ-020: Error clearing SHALL be that synchronized ctrl_sel_rst high clears addr_err.
REQ-021: FSM SHALL have states IDLE, PRST and ACTIVE.
REQ-022: In IDLE, addr=31, addr_valid=0, proj_rst=0 and ena=0.
REQ-023: IDLE->PRST SHALL occur on a synchronized ctrl_ena rising edge with shadow < NUM_PROJECTS; addr latches the shadow value and the reset-cycle counter loads RST_CYCLES.
REQ-024: Out-of-range request: on a ctrl_ena rising edge with shadow >= NUM_PROJECTS, the FSM SHALL stay in IDLE and set addr_err.
REQ-025: In PRST, proj_rst=1, ena=0 and addr_valid=1; the counter decrements each cycle.
REQ-026: PRST->ACTIVE SHALL occur after exactly RST_CYCLES cycles in PRST.
REQ-027: In ACTIVE, proj_rst=0, ena=1 and addr_valid=1, with addr held.
REQ-028: PRST or ACTIVE ->IDLE SHALL occur on the first cycle the synchronized ctrl_ena is low; proj_rst and ena drop at that edge and addr returns to 31.
REQ-029: Address stability: shadow counter changes SHALL never alter addr outside the IDLE->PRST transition.
REQ-030: ctrl_sel_rst during PRST or ACTIVE SHALL clear only the shadow counter and SHALL NOT affect the FSM.
REQ-031: A ctrl_ena rising edge while not in IDLE is impossible, because leaving PRST or ACTIVE requires ctrl_ena low.
REQ-032: All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-033: When rst is high at a clk edge, all synchronizer and delay flops, the shadow counter and the reset-cycle counter SHALL clear, the FSM SHALL enter IDLE, and outputs SHALL become addr=31, addr_valid=0, proj_rst=0, ena=0, addr_err=0.
REQ-034: Reset mid-operation (rst in PRST or ACTIVE) SHALL force the IDLE outputs at that same edge.
REQ-035: ctrl_ena held high through reset release SHALL be treated as a rising edge and commit the current shadow value (0) after SYNC_STAGES+1 cycles.

Verification
REQ-036: Scenario: 5 ctrl_sel_inc pulses, each 3 cycles high and 3 cycles low, then ctrl_ena high -> addr=5, proj_rst high exactly 8 cycles, then ena=1 and addr_valid=1.
REQ-037: Scenario: 40 inc pulses then ctrl_ena high -> shadow saturates at 31, FSM stays IDLE, addr_err=1, addr=31; a following ctrl_sel_rst pulse clears addr_err.
REQ-038: Scenario: ctrl_ena dropped 3 cycles into PRST -> proj_rst and ena low and addr=31 within SYNC_STAGES+1 cycles; ACTIVE is never entered.
REQ-039: Scenario: in ACTIVE at addr=7, 4 inc pulses then a sel_rst pulse -> addr stays 7 and ena stays 1 throughout.
REQ-040: Scenario: ctrl_sel_inc and ctrl_sel_rst rising in the same cycle -> shadow counter reads 0.
REQ-041: Scenario: rst asserted for 1 cycle in ACTIVE -> all outputs take reset values at that edge; with ctrl_ena still high, re-entry to PRST at addr=0 follows.
